sync_fifo_ext: RTL and testbench



---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_dpram.sv | 36 +++
 rtl/sync_fifo_ext.sv | 132 +++++++++++++
 tb/tb_sync_fifo_ext.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
// Read-mode selectors and the count-width helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointers and count carry one extra wrap bit.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM for the FIFO; no reset so it maps to block RAM.
// Ports: clk, we/waddr/wdata write port, re/raddr/rdata read port.
module fifo_dpram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_RD     = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
      end
    end else begin : g_comb
      // Head-register loader samples the array directly.
      logic unused_re;
      assign unused_re = re;
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_ext.sv
// Parametrised single-clock FIFO, standard or FWFT read, with thresholds.
// Ports: clk, rst, wren/wdat, rden, rdat/rvld, full, prefull, empty,
// preempty, count; ovf/udf only with SYNC_FIFO_ERR_FLAGS_EN defined.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int PREFULL_MARGIN  = 3,
  parameter int PREEMPTY_MARGIN = 2,
  parameter int FWFT            = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wren,
  input  logic [DATA_WIDTH-1:0]             wdat,
  input  logic                              rden,
  output logic [DATA_WIDTH-1:0]             rdat,
  output logic                              rvld,
  output logic                              full,
  output logic                              prefull,
  output logic                              empty,
  output logic                              preempty,
  output logic [count_width(ADDR_WIDTH)-1:0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                              ovf,
  output logic                              udf
`endif
);

  localparam int CW    = count_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] PF_LVL   = CW'(DEPTH - PREFULL_MARGIN);
  localparam logic [CW-1:0] PE_LVL   = CW'(PREEMPTY_MARGIN);

  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          wr_acc, rd_adv, vld_nxt, empty_nxt;
  logic [DATA_WIDTH-1:0] ram_q;

  assign wr_acc     = wren & ~full;
  assign wr_ptr_nxt = wr_ptr + CW'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + CW'(rd_adv);

  fifo_dpram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_RD     ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wdat),
    .re    (rd_adv),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      logic                  pop, load;
      logic [DATA_WIDTH-1:0] head;

      // Refill the head whenever it is vacant or leaving this cycle.
      assign pop       = rden & rvld;
      assign load      = (~rvld | pop) & (wr_ptr != rd_ptr);
      assign rd_adv    = load;
      assign vld_nxt   = load | (rvld & ~pop);
      assign empty_nxt = ~vld_nxt;
      // The held head word still counts as occupancy.
      assign count_nxt = wr_ptr_nxt - rd_ptr_nxt + CW'(vld_nxt);
      assign rdat      = head;

      always_ff @(posedge clk) begin
        if (rst) head <= '0;
        else if (load) head <= ram_q;
      end
    end else begin : g_std
      logic rd_zero;

      assign rd_adv    = rden & ~empty;
      assign vld_nxt   = rd_adv;
      assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;
      assign empty_nxt = (count_nxt == '0);
      // RAM output has no reset; mask it until the first read.
      assign rdat      = rd_zero ? '0 : ram_q;

      always_ff @(posedge clk) begin
        if (rst) rd_zero <= 1'b1;
        else if (rd_adv) rd_zero <= 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rvld     <= 1'b0;
      full     <= 1'b0;
      prefull  <= 1'b0;
      empty    <= 1'b1;
      preempty <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rvld     <= vld_nxt;
      full     <= (count_nxt == FULL_LVL);
      prefull  <= (count_nxt >= PF_LVL);
      empty    <= empty_nxt;
      preempty <= (count_nxt <= PE_LVL);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wren & full) ovf <= 1'b1;
      if (rden & empty) udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: one standard and one FWFT instance.
// Each task drives its scenario and checks against hand-computed values.
module tb_sync_fifo_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wren = 1'b0, rden = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] s_rdat;
  logic        s_rvld, s_full, s_prefull, s_empty, s_preempty;
  logic [4:0]  s_count;
  logic        f_wren = 1'b0, f_rden = 1'b0;
  logic [31:0] f_wdat = '0;
  logic [31:0] f_rdat;
  logic        f_rvld, f_full, f_prefull, f_empty, f_preempty;
  logic [4:0]  f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic        s_ovf, s_udf, f_ovf, f_udf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wren(wren), .wdat(wdat), .rden(rden),
    .rdat(s_rdat), .rvld(s_rvld), .full(s_full), .prefull(s_prefull),
    .empty(s_empty), .preempty(s_preempty), .count(s_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .ovf(s_ovf), .udf(s_udf)
`endif
  );

  sync_fifo_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wren(f_wren), .wdat(f_wdat), .rden(f_rden),
    .rdat(f_rdat), .rvld(f_rvld), .full(f_full), .prefull(f_prefull),
    .empty(f_empty), .preempty(f_preempty), .count(f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .ovf(f_ovf), .udf(f_udf)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wren = 0; rden = 0; f_wren = 0; f_rden = 0;
    step();
    rst = 1'b0;
    tests++; if (s_count !== 5'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", s_count); end
    tests++; if ({s_full, s_prefull, s_empty, s_preempty} !== 4'b0011) begin fails++; $display("FAIL rst_flags got=%b exp=0011", {s_full, s_prefull, s_empty, s_preempty}); end
    tests++; if (s_rvld !== 1'b0 || s_rdat !== 32'h0) begin fails++; $display("FAIL rst_rd got=%b/%h exp=0/0", s_rvld, s_rdat); end
    tests++; if (f_rvld !== 1'b0 || f_empty !== 1'b1 || f_count !== 5'd0) begin fails++; $display("FAIL rst_fwft got=%b/%b/%0d exp=0/1/0", f_rvld, f_empty, f_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wren = 1; wdat = 32'h100 + i;
      step();
      tests++; if (s_count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, i + 1); end
      tests++; if (s_prefull !== (i + 1 >= 13)) begin fails++; $display("FAIL fill_prefull[%0d] got=%b exp=%b", i, s_prefull, (i + 1 >= 13)); end
      tests++; if (s_full !== (i + 1 == 16)) begin fails++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, s_full, (i + 1 == 16)); end
      tests++; if (s_preempty !== (i + 1 <= 2)) begin fails++; $display("FAIL fill_preempty[%0d] got=%b exp=%b", i, s_preempty, (i + 1 <= 2)); end
    end
    wdat = 32'hDEAD;
    step();
    wren = 0;
    tests++; if (s_count !== 5'd16 || s_full !== 1'b1) begin fails++; $display("FAIL fill_over got=%0d/%b exp=16/1", s_count, s_full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    tests++; if (s_ovf !== 1'b1) begin fails++; $display("FAIL fill_ovf got=%b exp=1", s_ovf); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rden = 1;
      step();
      tests++; if (s_rvld !== 1'b1 || s_rdat !== 32'h100 + i) begin fails++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, s_rvld, s_rdat, 32'h100 + i); end
      tests++; if (s_count !== 5'(15 - i)) begin fails++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, s_count, 15 - i); end
    end
    rden = 0;
    step();
    tests++; if (s_empty !== 1'b1 || s_rvld !== 1'b0 || s_rdat !== 32'h10F) begin fails++; $display("FAIL drain_hold got=%b/%b/%h exp=1/0/10f", s_empty, s_rvld, s_rdat); end
    rden = 1;
    step();
    rden = 0;
    tests++; if (s_rvld !== 1'b0 || s_rdat !== 32'h10F || s_count !== 5'd0) begin fails++; $display("FAIL drain_under got=%b/%h/%0d exp=0/10f/0", s_rvld, s_rdat, s_count); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    tests++; if (s_udf !== 1'b1) begin fails++; $display("FAIL drain_udf got=%b exp=1", s_udf); end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      wren = 1; wdat = 32'h300 + i;
      step();
    end
    for (int k = 0; k < 40; k++) begin
      wren = 1; rden = 1; wdat = 32'h308 + k;
      step();
      tests++; if (s_rvld !== 1'b1 || s_rdat !== 32'h300 + k) begin fails++; $display("FAIL wrap_data[%0d] got=%b/%h exp=1/%h", k, s_rvld, s_rdat, 32'h300 + k); end
      tests++; if (s_count !== 5'd8) begin fails++; $display("FAIL wrap_count[%0d] got=%0d exp=8", k, s_count); end
    end
    wren = 0; rden = 0;
    step();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) begin
      wren = 1; wdat = 32'h200 + i;
      step();
    end
    tests++; if (s_full !== 1'b1) begin fails++; $display("FAIL fs_full got=%b exp=1", s_full); end
    wren = 1; rden = 1; wdat = 32'hBEEF;
    step();
    wren = 0;
    tests++; if (s_count !== 5'd15 || s_full !== 1'b0) begin fails++; $display("FAIL fs_count got=%0d/%b exp=15/0", s_count, s_full); end
    tests++; if (s_rvld !== 1'b1 || s_rdat !== 32'h200) begin fails++; $display("FAIL fs_read got=%b/%h exp=1/200", s_rvld, s_rdat); end
    for (int i = 0; i < 15; i++) begin
      step();
    end
    rden = 0;
    tests++; if (s_rdat !== 32'h20F || s_count !== 5'd0 || s_empty !== 1'b1) begin fails++; $display("FAIL fs_dropped got=%h/%0d/%b exp=20f/0/1", s_rdat, s_count, s_empty); end
  endtask

  task automatic test_fwft();
    f_wren = 1; f_wdat = 32'hABCD;
    step();
    f_wren = 0;
    tests++; if (f_rvld !== 1'b0 || f_count !== 5'd1) begin fails++; $display("FAIL fwft_n got=%b/%0d exp=0/1", f_rvld, f_count); end
    step();
    tests++; if (f_rvld !== 1'b1 || f_rdat !== 32'hABCD || f_empty !== 1'b0) begin fails++; $display("FAIL fwft_n1 got=%b/%h/%b exp=1/abcd/0", f_rvld, f_rdat, f_empty); end
    f_rden = 1;
    step();
    f_rden = 0;
    tests++; if (f_rvld !== 1'b0 || f_empty !== 1'b1 || f_count !== 5'd0) begin fails++; $display("FAIL fwft_pop got=%b/%b/%0d exp=0/1/0", f_rvld, f_empty, f_count); end
    for (int i = 1; i <= 3; i++) begin
      f_wren = 1; f_wdat = 32'h11 * i;
      step();
    end
    f_wren = 0;
    step();
    for (int j = 1; j <= 3; j++) begin
      tests++; if (f_rvld !== 1'b1 || f_rdat !== 32'h11 * j) begin fails++; $display("FAIL fwft_b2b[%0d] got=%b/%h exp=1/%h", j, f_rvld, f_rdat, 32'h11 * j); end
      f_rden = 1;
      step();
    end
    f_rden = 0;
    tests++; if (f_rvld !== 1'b0 || f_count !== 5'd0) begin fails++; $display("FAIL fwft_b2b_end got=%b/%0d exp=0/0", f_rvld, f_count); end
  endtask

  task automatic test_rst_mid();
    rden = 1;
    step();
    rden = 0;
    for (int i = 0; i < 10; i++) begin
      wren = 1; wdat = 32'h400 + i;
      step();
    end
    wren = 0; rden = 1;
    step();
    tests++; if (s_count !== 5'd9 || s_rdat !== 32'h400) begin fails++; $display("FAIL mid_pre got=%0d/%h exp=9/400", s_count, s_rdat); end
    rst = 1;
    step();
    rst = 0; rden = 0;
    tests++; if (s_count !== 5'd0 || s_empty !== 1'b1 || s_preempty !== 1'b1) begin fails++; $display("FAIL mid_state got=%0d/%b/%b exp=0/1/1", s_count, s_empty, s_preempty); end
    tests++; if (s_rvld !== 1'b0 || s_rdat !== 32'h0) begin fails++; $display("FAIL mid_rd got=%b/%h exp=0/0", s_rvld, s_rdat); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    tests++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin fails++; $display("FAIL mid_err got=%b/%b exp=0/0", s_ovf, s_udf); end
`endif
  endtask

  initial begin
    step();
    test_reset();
    test_fill();
    test_drain();
    test_reset();
    test_wrap();
    test_reset();
    test_full_simul();
    test_reset();
    test_fwft();
    test_reset();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
